uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 116 +++++++++++
 tb/tb_uart_tx.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-word holding register feeding a
// start/data/stop serializer; default frames match uart_rx bit-for-bit.
module uart_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 9,
    parameter int STOP_BITS = 1
) (
    input  logic                 uclk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int BPS_CNT = CLK_FREQ / BAUD;
    localparam int CW = $clog2(BPS_CNT * STOP_BITS);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] BIT_END = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] STOP_END = CW'(BPS_CNT * STOP_BITS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] hold;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nx;
    logic                 hold_full;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 accept;
    logic                 load;
    logic                 bit_end;
    logic                 stop_end;

    assign tx_ready = !hold_full;
    assign accept   = tx_valid && !hold_full;
    assign bit_end  = (baud_cnt == BIT_END);
    assign stop_end = (state == STOP) && (baud_cnt == STOP_END);
    // A pending word chains straight into the next frame at stop expiry.
    assign load     = hold_full && ((state == IDLE) || stop_end);
    assign shift_nx = shift >> 1;

    always_ff @(posedge uclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            txd       <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= stop_end;
            if (accept) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end
            if (load) begin
                hold_full <= 1'b0;
                shift     <= hold;
                baud_cnt  <= '0;
                bit_cnt   <= '0;
                txd       <= 1'b0;
                tx_busy   <= 1'b1;
                state     <= START;
            end else begin
                unique case (state)
                    IDLE: begin
                        txd     <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            txd      <= shift[0];
                            state    <= DATA;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (bit_cnt == LAST_BIT) begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                shift   <= shift_nx;
                                txd     <= shift_nx[0];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (stop_end) begin
                            baud_cnt <= '0;
                            tx_busy  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx at default rates, plus a fast
// instance looped into a bench-side receiver.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int BPS    = 50000000 / 115200;
    localparam int FRAME  = (1 + 9 + 1) * BPS;
    localparam int FB     = 800 / 100;
    localparam int FFRAME = (1 + 9 + 2) * FB;

    logic       uclk = 1'b0;
    logic       rst_n;
    logic [8:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;
    logic [8:0] f_data;
    logic       f_valid;
    logic       f_ready;
    logic       f_txd;
    logic       f_busy;
    logic       f_done;

    int total   = 0;
    int bad     = 0;
    int done_n  = 0;
    int acc_n   = 0;
    int fdone_n = 0;
    int rx_err_n = 0;
    logic [8:0] rx_q[$];

    always #10 uclk = ~uclk;

    uart_tx dut (
        .uclk     (uclk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    uart_tx #(
        .CLK_FREQ  (800),
        .BAUD      (100),
        .DATA_BITS (9),
        .STOP_BITS (2)
    ) dut_f (
        .uclk     (uclk),
        .rst_n    (rst_n),
        .tx_data  (f_data),
        .tx_valid (f_valid),
        .tx_ready (f_ready),
        .txd      (f_txd),
        .tx_busy  (f_busy),
        .tx_done  (f_done)
    );

    always @(posedge uclk) begin
        if (rst_n && tx_done) done_n <= done_n + 1;
        if (rst_n && tx_valid && tx_ready) acc_n <= acc_n + 1;
        if (rst_n && f_done) fdone_n <= fdone_n + 1;
    end

    // Mid-bit sampling receiver for the fast instance (8 clocks/bit, 2 stop).
    always begin : rx_model
        logic [8:0] w;
        logic       e;
        @(negedge f_txd);
        e = 1'b0;
        w = '0;
        repeat (FB / 2) @(posedge uclk);
        #1;
        if (f_txd !== 1'b0) e = 1'b1;
        for (int i = 0; i < 9; i++) begin
            repeat (FB) @(posedge uclk);
            #1;
            w[i] = f_txd;
        end
        for (int i = 0; i < 2; i++) begin
            repeat (FB) @(posedge uclk);
            #1;
            if (f_txd !== 1'b1) e = 1'b1;
        end
        rx_q.push_back(w);
        if (e) rx_err_n++;
    end

    function automatic logic exp_bit(input logic [8:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 9) return w[idx-1];
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge uclk);
        #1;
    endtask

    task automatic test_reset();
        int errs = 0;
        tx_valid = 1'b0;
        f_valid  = 1'b0;
        tx_data  = 9'h1A5;
        f_data   = 9'h05A;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tx_valid = ~tx_valid;
            f_valid  = tx_valid;
            tick();
            if ({txd, tx_ready, tx_busy, tx_done} !== 4'b1100 ||
                {f_txd, f_ready, f_busy, f_done} !== 4'b1100) begin
                if (errs == 0)
                    $display("FAIL reset_hold: txd/rdy/busy/done=%b%b%b%b need 1100",
                             txd, tx_ready, tx_busy, tx_done);
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;
        tx_valid = 1'b0;
        f_valid  = 1'b0;
        rst_n    = 1'b1;
        repeat (3) tick();
        total++;
        if ({txd, tx_ready, tx_busy, tx_done} !== 4'b1100 || f_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: txd/rdy/busy/done=%b%b%b%b f_busy=%b need 1100 0",
                     txd, tx_ready, tx_busy, tx_done, f_busy);
        end
    endtask

    task automatic test_single();
        int errs = 0;
        int d0 = done_n;
        tx_data  = 9'h155;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 9'h000;
        total++;
        if (tx_ready !== 1'b0 || txd !== 1'b1) begin
            bad++;
            $display("FAIL single_accept: ready=%b txd=%b need ready=0 txd=1", tx_ready, txd);
        end
        for (int k = 1; k <= FRAME; k++) begin
            tick();
            if (txd !== exp_bit(9'h155, (k - 1) / BPS) || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
                if (errs == 0)
                    $display("FAIL single_frame: E+%0d txd=%b busy=%b done=%b need txd=%b busy=1 done=0",
                             k, txd, tx_busy, tx_done, exp_bit(9'h155, (k - 1) / BPS));
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;
        tick();
        total++;
        if ({tx_done, tx_busy, txd} !== 3'b101) begin
            bad++;
            $display("FAIL single_end: done/busy/txd=%b%b%b need 101", tx_done, tx_busy, txd);
        end
        tick();
        total++;
        if (tx_done !== 1'b0 || (done_n - d0) != 1) begin
            bad++;
            $display("FAIL single_done_once: done=%b pulses=%0d need done=0 pulses=1",
                     tx_done, done_n - d0);
        end
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        int d0 = done_n;
        tx_data  = 9'h001;
        tx_valid = 1'b1;
        tick();
        tx_data = 9'h1FF;
        tick();
        total++;
        if (txd !== 1'b0 || tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_load: txd=%b ready=%b need txd=0 ready=1", txd, tx_ready);
        end
        tick();
        tx_valid = 1'b0;
        total++;
        if (tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept2: ready=%b need 0", tx_ready);
        end
        for (int k = 3; k <= FRAME; k++) begin
            tick();
            if (txd !== exp_bit(9'h001, (k - 1) / BPS) || tx_ready !== 1'b0 || tx_done !== 1'b0) begin
                if (errs == 0)
                    $display("FAIL b2b_first: E+%0d txd=%b ready=%b done=%b need txd=%b ready=0 done=0",
                             k, txd, tx_ready, tx_done, exp_bit(9'h001, (k - 1) / BPS));
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;
        tick();
        total++;
        if ({tx_done, txd, tx_busy, tx_ready} !== 4'b1011) begin
            bad++;
            $display("FAIL b2b_seam: done/txd/busy/ready=%b%b%b%b need 1011",
                     tx_done, txd, tx_busy, tx_ready);
        end
        errs = 0;
        for (int j = 1; j < FRAME; j++) begin
            tick();
            if (txd !== exp_bit(9'h1FF, j / BPS) || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
                if (errs == 0)
                    $display("FAIL b2b_second: S+%0d txd=%b busy=%b done=%b need txd=%b busy=1 done=0",
                             j, txd, tx_busy, tx_done, exp_bit(9'h1FF, j / BPS));
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;
        tick();
        total++;
        if ({tx_done, tx_busy, txd} !== 3'b101) begin
            bad++;
            $display("FAIL b2b_end: done/busy/txd=%b%b%b need 101", tx_done, tx_busy, txd);
        end
        tick();
        total++;
        if ((done_n - d0) != 2) begin
            bad++;
            $display("FAIL b2b_count: pulses=%0d need 2", done_n - d0);
        end
    endtask

    task automatic test_reset_mid();
        int errs = 0;
        int d0 = done_n;
        tx_data  = 9'h0AA;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        tx_data  = 9'h0F0;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        total++;
        if (tx_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_buffer: ready=%b need 0", tx_ready);
        end
        repeat (4 * BPS + BPS / 2 - 2) tick();
        total++;
        if (txd !== exp_bit(9'h0AA, 4) || tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_bit3: txd=%b busy=%b need txd=%b busy=1",
                     txd, tx_busy, exp_bit(9'h0AA, 4));
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({txd, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            bad++;
            $display("FAIL mid_async: txd/rdy/busy/done=%b%b%b%b need 1100",
                     txd, tx_ready, tx_busy, tx_done);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4 * BPS; k++) begin
            tick();
            if ({txd, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
                if (errs == 0)
                    $display("FAIL mid_idle: +%0d txd/rdy/busy/done=%b%b%b%b need 1100",
                             k, txd, tx_ready, tx_busy, tx_done);
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;
        total++;
        if (done_n != d0) begin
            bad++;
            $display("FAIL mid_no_done: pulses=%0d need 0", done_n - d0);
        end
        errs = 0;
        tx_data  = 9'h055;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            tick();
            if (txd !== exp_bit(9'h055, (k - 1) / BPS) || tx_busy !== 1'b1) begin
                if (errs == 0)
                    $display("FAIL mid_next_frame: E+%0d txd=%b busy=%b need txd=%b busy=1",
                             k, txd, tx_busy, exp_bit(9'h055, (k - 1) / BPS));
                errs++;
            end
        end
        total++;
        if (errs != 0) bad++;
        tick();
        total++;
        if ({tx_done, tx_busy, txd} !== 3'b101) begin
            bad++;
            $display("FAIL mid_next_end: done/busy/txd=%b%b%b need 101", tx_done, tx_busy, txd);
        end
    endtask

    task automatic test_held_valid();
        int errs = 0;
        int a0 = acc_n;
        logic dn;
        tx_data  = 9'h123;
        tx_valid = 1'b1;
        tick();
        for (int k = 1; k <= 3 * FRAME; k++) begin
            tick();
            dn = (k > 1) && ((k - 1) % FRAME == 0);
            if (txd !== exp_bit(9'h123, ((k - 1) / BPS) % 11) || tx_busy !== 1'b1 || tx_done !== dn) begin
                if (errs == 0)
                    $display("FAIL held_frames: E+%0d txd=%b busy=%b done=%b need txd=%b busy=1 done=%b",
                             k, txd, tx_busy, tx_done, exp_bit(9'h123, ((k - 1) / BPS) % 11), dn);
                errs++;
            end
        end
        tx_valid = 1'b0;
        total++;
        if (errs != 0) bad++;
        total++;
        if ((acc_n - a0) != 4) begin
            bad++;
            $display("FAIL held_accepts: accepts=%0d need 4", acc_n - a0);
        end
        repeat (FRAME + 20) tick();
        total++;
        if ({txd, tx_ready, tx_busy} !== 3'b110) begin
            bad++;
            $display("FAIL held_drain: txd/rdy/busy=%b%b%b need 110", txd, tx_ready, tx_busy);
        end
    endtask

    task automatic test_loopback();
        int fd0 = fdone_n;
        int n;
        logic stuck = 1'b0;
        for (int w = 1; w <= 100 && !stuck; w++) begin
            f_data  = 9'(w);
            f_valid = 1'b1;
            n = 0;
            while (f_ready !== 1'b1 && n < 2 * FFRAME) begin
                tick();
                n++;
            end
            if (n >= 2 * FFRAME) begin
                total++;
                bad++;
                stuck = 1'b1;
                $display("FAIL lb_ready_timeout: word %0d ready=%b need 1", w, f_ready);
            end else begin
                tick();
            end
            f_valid = 1'b0;
        end
        repeat (2 * FFRAME + 10) tick();
        total++;
        if (rx_q.size() != 100) begin
            bad++;
            $display("FAIL lb_count: received=%0d need 100", rx_q.size());
        end
        for (int i = 0; i < 100 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== 9'(i + 1)) begin
                bad++;
                $display("FAIL lb_word: index %0d got %h need %h", i, rx_q[i], 9'(i + 1));
            end
        end
        total++;
        if (rx_err_n != 0) begin
            bad++;
            $display("FAIL lb_rx_err: framing errors=%0d need 0", rx_err_n);
        end
        total++;
        if ((fdone_n - fd0) != 100) begin
            bad++;
            $display("FAIL lb_tx_done: pulses=%0d need 100", fdone_n - fd0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_held_valid();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
